multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core_if.sv | 34 +++
 rtl/multicycle_core.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_core.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// ---------------------------------------------------------------------------
// multicycle_core_if : instruction-fetch and data-memory handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_core_if #(
  parameter int PC_BITS = 9,
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 9
);
  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               dmem_req;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_data, dmem_ack, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_core.sv
// ---------------------------------------------------------------------------
// multicycle_core : 8-op accumulator-free multicycle CPU with req/ack memories
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_core #(
  parameter int PC_BITS  = 9,
  parameter int DATA_W   = 8,
  parameter int REG_BITS = 3
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         run,
  multicycle_core_if.master bus,
  output logic [PC_BITS-1:0] pc,
  output logic               halted,
  output logic [15:0]        retired
);
  localparam int INSTR_W = 3 + 2*REG_BITS;
  localparam int NREGS   = 2**REG_BITS;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_BZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              r_state;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [PC_BITS-1:0]  r_pc;
  logic                r_halted;
  logic [15:0]         r_retired;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic [DATA_W-1:0]   r_dmem_addr;
  logic [DATA_W-1:0]   r_dmem_wdata;

  logic [2:0]          w_op;
  logic [REG_BITS-1:0] w_r1;
  logic [REG_BITS-1:0] w_r2;
  logic [PC_BITS-1:0]  w_pc_inc;
  logic [PC_BITS-1:0]  w_br_tgt;
  logic [DATA_W-1:0]   w_alu;
  logic                w_imem_req;

  assign w_op     = r_ir[INSTR_W-1 -: 3];
  assign w_r1     = r_ir[2*REG_BITS-1 -: REG_BITS];
  assign w_r2     = r_ir[REG_BITS-1:0];
  assign w_pc_inc = r_pc + PC_BITS'(1);

  // Fetch request follows run directly so it rises in the first run cycle,
  // and is gated by reset so it drops the instant reset is asserted.
  assign w_imem_req = (r_state == S_FETCH) && run && reset;

  generate
    if (DATA_W >= PC_BITS) begin : g_tgt_trunc
      assign w_br_tgt = r_b[PC_BITS-1:0];
    end else begin : g_tgt_zext
      assign w_br_tgt = {{(PC_BITS-DATA_W){1'b0}}, r_b};
    end
  endgenerate

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_pc         <= '0;
      r_halted     <= 1'b0;
      r_retired    <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_imem_req && bus.imem_ack) begin
            r_ir    <= bus.imem_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_regs[w_r1];
          r_b     <= r_regs[w_r2];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          case (w_op)
            OP_LD, OP_ST: begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= (w_op == OP_ST);
              r_dmem_addr  <= r_b;
              r_dmem_wdata <= (w_op == OP_ST) ? r_a : '0;
              r_state      <= S_MEM;
            end
            OP_BZ: begin
              r_pc      <= (r_a == '0) ? w_br_tgt : w_pc_inc;
              r_retired <= r_retired + 16'd1;
              r_state   <= S_FETCH;
            end
            OP_HALT: begin
              r_halted  <= 1'b1;
              r_retired <= r_retired + 16'd1;
              r_state   <= S_HALT;
            end
            default: begin
              r_result <= w_alu;
              r_state  <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (r_dmem_req && bus.dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_dmem_we) begin
              r_pc      <= w_pc_inc;
              r_retired <= r_retired + 16'd1;
              r_state   <= S_FETCH;
            end else begin
              r_result <= bus.dmem_rdata;
              r_state  <= S_WB;
            end
          end
        end
        S_WB: begin
          r_regs[w_r1] <= r_result;
          r_pc         <= w_pc_inc;
          r_retired    <= r_retired + 16'd1;
          r_state      <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign pc             = r_pc;
  assign halted         = r_halted;
  assign retired        = r_retired;
endmodule

`default_nettype wire

// File: tb/tb_multicycle_core.sv
// ---------------------------------------------------------------------------
// tb_multicycle_core : directed programs against memory models + store queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_core;
  localparam int PC_BITS  = 9;
  localparam int DATA_W   = 8;
  localparam int REG_BITS = 3;
  localparam int INSTR_W  = 9;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               run   = 1'b0;
  logic [PC_BITS-1:0] pc;
  logic               halted;
  logic [15:0]        retired;

  multicycle_core_if #(.PC_BITS(PC_BITS), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) bus ();

  multicycle_core #(.PC_BITS(PC_BITS), .DATA_W(DATA_W), .REG_BITS(REG_BITS)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .pc      (pc),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clock = ~clock;

  logic [INSTR_W-1:0] imem [512];
  logic [7:0]         dmem [256];
  logic [15:0]        sb_q [$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t_ret  = 0;
  int idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;
  logic m_iack = 1'b0, m_dack = 1'b0, f_ack = 1'b0;
  logic [PC_BITS-1:0] i_snap;
  logic [16:0]        d_snap;

  assign bus.imem_ack   = m_iack | f_ack;
  assign bus.dmem_ack   = m_dack | f_ack;
  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory models: acks are decided at the falling edge, so requests are
  // sampled mid-cycle and stores are scored against the expectation queue.
  always @(negedge clock) begin
    if (bus.imem_req) begin
      if (icnt == 0) i_snap = bus.imem_addr;
      m_iack = (icnt >= idelay);
      if (m_iack && icnt > 0) check("imem_addr_stable", bus.imem_addr, i_snap);
      icnt++;
    end else begin
      m_iack = 1'b0;
      icnt   = 0;
    end
    if (bus.dmem_req) begin
      if (dcnt == 0) d_snap = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
      m_dack = (dcnt >= ddelay);
      if (m_dack) begin
        if (dcnt > 0) check("dmem_stable", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, d_snap);
        if (bus.dmem_we) begin
          check("store_expected", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) check("store", {bus.dmem_addr, bus.dmem_wdata}, sb_q.pop_front());
          dmem[bus.dmem_addr] = bus.dmem_wdata;
        end
      end
      dcnt++;
    end else begin
      m_dack = 1'b0;
      dcnt   = 0;
    end
  end

  function automatic logic [INSTR_W-1:0] ins(input logic [2:0] op, input int r1, input int r2);
    return {op, 3'(r1), 3'(r2)};
  endfunction

  task automatic wait_retired(input int n, input int budget, input string tag);
    int k = 0;
    while (retired < 16'(n) && k < budget) begin
      @(posedge clock);
      #1;
      k++;
    end
    check(tag, retired, n);
    t_ret = cyc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) imem[i] = ins(3'd7, 0, 0);
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, bus.imem_req, 0);
    check({tag, "_dmem_req"}, bus.dmem_req, 0);
    check({tag, "_dmem_we"}, bus.dmem_we, 0);
    check({tag, "_dmem_addr"}, bus.dmem_addr, 0);
    check({tag, "_dmem_wdata"}, bus.dmem_wdata, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_retired"}, retired, 0);
  endtask

  initial begin
    int t0, reqs, k;

    // Phase A: arithmetic wrap, store, halt, latencies with zero-wait memories
    clear_mem();
    imem[0] = ins(3'd4, 1, 0);
    imem[1] = ins(3'd4, 2, 1);
    imem[2] = ins(3'd0, 1, 2);
    imem[3] = ins(3'd5, 1, 0);
    imem[4] = ins(3'd7, 0, 0);
    dmem[0]   = 8'd200;
    dmem[200] = 8'd100;
    sb_q.push_back({8'd0, 8'd44});
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("rst");
    reset = 1'b1;
    @(posedge clock);
    #1 check("idle_no_req", bus.imem_req, 0);
    run = 1'b1;
    #1 check("first_req", bus.imem_req, 1);
    wait_retired(2, 100, "A_ret2");
    t0 = t_ret;
    wait_retired(3, 100, "A_ret3");
    check("add_latency", t_ret - t0, 4);
    check("A_pc3", pc, 3);
    t0 = t_ret;
    wait_retired(4, 100, "A_ret4");
    check("st_latency", t_ret - t0, 4);
    t0 = t_ret;
    wait_retired(5, 100, "A_ret5");
    check("halt_latency", t_ret - t0, 3);
    check("halted", halted, 1);
    reqs = 0;
    repeat (20) begin
      @(posedge clock);
      #1 if (bus.imem_req || bus.dmem_req) reqs++;
    end
    check("halt_no_req", reqs, 0);
    check("halt_pc", pc, 4);
    check("halt_retired", retired, 5);
    check("A_sb_empty", sb_q.size(), 0);

    // Phase B: all ALU ops, load-after-store, branches, stretched handshakes
    reset = 1'b0;
    clear_mem();
    imem[0]  = ins(3'd4, 2, 0);
    imem[1]  = ins(3'd4, 1, 2);
    imem[2]  = ins(3'd3, 1, 2);
    imem[3]  = ins(3'd5, 1, 2);
    imem[4]  = ins(3'd4, 3, 2);
    imem[5]  = ins(3'd5, 3, 0);
    imem[6]  = ins(3'd1, 1, 2);
    imem[7]  = ins(3'd5, 1, 0);
    imem[8]  = ins(3'd2, 1, 2);
    imem[9]  = ins(3'd5, 1, 0);
    imem[10] = ins(3'd4, 4, 1);
    imem[11] = ins(3'd6, 0, 4);
    imem[16] = ins(3'd6, 1, 4);
    imem[17] = ins(3'd7, 0, 0);
    dmem[0] = 8'h07;
    dmem[3] = 8'h10;
    dmem[7] = 8'h5D;
    sb_q.push_back({8'h07, 8'h5A});
    sb_q.push_back({8'h00, 8'h5A});
    sb_q.push_back({8'h00, 8'h53});
    sb_q.push_back({8'h00, 8'h03});
    idelay = 5;
    ddelay = 3;
    @(posedge clock);
    #1 check("B_rst_halted", halted, 0);
    reset = 1'b1;
    wait_retired(12, 400, "B_ret12");
    check("bz_taken_pc", pc, 9'h010);
    wait_retired(13, 100, "B_ret13");
    check("bz_not_taken_pc", pc, 9'h011);
    wait_retired(14, 100, "B_ret14");
    check("B_halted", halted, 1);
    check("B_pc", pc, 9'h011);
    check("B_sb_empty", sb_q.size(), 0);

    // Phase C: reset mid-load, late acks ignored, pc wrap at 511
    reset = 1'b0;
    clear_mem();
    imem[0] = ins(3'd4, 2, 0);
    imem[1] = ins(3'd4, 1, 2);
    imem[2] = ins(3'd5, 1, 0);
    for (int i = 3; i < 512; i++) imem[i] = ins(3'd0, 5, 5);
    dmem[0]    = 8'h40;
    dmem[8'h40] = 8'h21;
    idelay = 0;
    ddelay = 10;
    @(posedge clock);
    #1 reset = 1'b1;
    wait_retired(1, 100, "C_ret1");
    k = 0;
    while (!bus.dmem_req && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("C_ld_in_mem", bus.dmem_req, 1);
    check("C_ld_addr", bus.dmem_addr, 8'h40);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_reset_outputs("midld");
    ddelay = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    f_ack = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("late_ack_pc", pc, 0);
    check("late_ack_retired", retired, 0);
    check("late_ack_no_req", bus.imem_req, 0);
    f_ack = 1'b0;
    sb_q.push_back({8'h00, 8'h21});
    run = 1'b1;
    wait_retired(3, 100, "C_ret3");
    check("C_sb_empty", sb_q.size(), 0);
    wait_retired(512, 4000, "C_ret512");
    check("wrap_pc", pc, 0);
    check("wrap_imem_addr", bus.imem_addr, 0);
    run = 1'b0;
    #1 check("run_low_no_req", bus.imem_req, 0);
    repeat (5) @(posedge clock);
    #1 check("run_low_retired", retired, 512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
